fx2_ep_fifo: RTL and testbench
==============================

// Module: fx2_ep_fifo
// PURPOSE
//  Cycle-level model of one Cypress FX2 slave-FIFO endpoint, used in simulation fixtures.
//  Parameterised as OUT (host->FPGA, FPGA pops with SLRD#) or IN (FPGA->host, FPGA pushes with SLWR#).
//  The fixture instantiates it once per endpoint: EP2 = OUT at address 2'b00, EP6 = IN at 2'b10.
//  A host-side port lets the bench act as the USB host, filling OUT endpoints and draining IN endpoints.
// PARAMETERS
//  FIFOADR  2'b00  FIFOADR[1:0] value this endpoint answers to
//  DIR      0      0 = OUT endpoint (FPGA reads), 1 = IN endpoint (FPGA writes)
//  DEPTH    512    entries; must be a power of 2
//  AW       9      log2(DEPTH)
// PORTS
//  ifclk        in   1     interface clock; all state updates on the rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  fifoadr      in   2     endpoint select driven by the FPGA
//  strobe_n     in   1     SLRD# (DIR=0) or SLWR# (DIR=1); active-low
//  fpga_wdata   in   8     FD value sampled on a push (DIR=1 only)
//  fpga_rdata   out  8     head word presented on FD (DIR=0), first-word-fall-through
//  flag_n       out  1     EMPTY# (DIR=0) or FULL# (DIR=1); active-low
//  host_wr      in   1     host push strobe, active-high (DIR=0 only)
//  host_wdata   in   8     host push data
//  host_rd      in   1     host pop strobe, active-high (DIR=1 only)
//  host_rdata   out  8     head word for the host (DIR=1), first-word-fall-through
//  count        out  AW+1  current occupancy, 0..DEPTH
//  err          out  1     sticky: overflow or underflow attempted
// BEHAVIOUR
//  Reset (async, reset_n=0): pointers=0, count=0, err=0, fpga_rdata=host_rdata=8'h00.
//   flag_n=0 for DIR=0 (empty asserted); flag_n=1 for DIR=1 (not full).
//  sel = (fifoadr == FIFOADR). FPGA access occurs when sel && !strobe_n at the ifclk edge.
//  DIR=0: FPGA access pops if count!=0; otherwise ignored and err<=1. host_wr pushes if count!=DEPTH;
//   otherwise dropped and err<=1.
//  DIR=1: FPGA access pushes fpga_wdata if count!=DEPTH; otherwise dropped and err<=1.
//   host_rd pops if count!=0; otherwise ignored and err<=1.
//  Strobes on the port not used by DIR are ignored and do not set err.
//  Read data: mem[rd_ptr] combinational when count!=0, else 8'h00; next word visible the cycle after a pop.
//  Simultaneous push+pop in one cycle: both occur when individually legal; count unchanged.
//   When full, the push is refused even if a pop happens the same cycle.
//   When empty, the pop is refused even if a push happens the same cycle.
//  flag_n is decoded from registered count, so it updates one cycle after the access that changes count.
//   DIR=0: flag_n = (count!=0). DIR=1: flag_n = (count!=DEPTH).
//  Pointers are AW bits and wrap modulo DEPTH; count is AW+1 bits so a full FIFO is distinguishable.
//  err clears only on reset.
//  Reset mid-transfer discards all contents immediately; no write is performed in the reset cycle.
// STRUCTURE
//  Package fx2_pkg: FIFOADR constants EP2=2'b00, EP4=2'b01, EP6=2'b10, EP8=2'b11;
//   DIR_OUT=0 and DIR_IN=1; data width constant FD_W=8.
//  Sub-module fx2_fifo_core: synchronous single-clock FIFO (mem, rd/wr ptr, count, push/pop guards).
//  fx2_ep_fifo adds address decode, strobe polarity, DIR muxing of push/pop sources, flag and err.
// TESTING
//  Reset: DIR=0 -> flag_n=0, count=0; DIR=1 -> flag_n=1, err=0.
//  DIR=0, FIFOADR=00: host pushes 8'hA5, 8'h3C; FPGA holds fifoadr=00, strobe_n=0 two cycles
//   -> fpga_rdata A5 then 3C, count 2->0, flag_n=0 one cycle after the second pop.
//  DIR=0, fifoadr=01 with strobe_n=0 -> no pop, count unchanged, err=0.
//  DIR=1, FIFOADR=10: DEPTH pushes 0..255 wrapping -> flag_n=0 after last;
//   one extra push dropped and err=1; host pops return 8'h00, 8'h01, ...
//  Simultaneous: count=3, push and pop same cycle -> count stays 3, order preserved.
//   Empty + pop + push -> count=1, err=1.
//  Reset asserted mid-stream with count=5 -> count=0 immediately, flags at reset values.

Source files
------------

// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO endpoint model: endpoint addresses,
// direction codes and the FD bus width.
package fx2_pkg;
    localparam logic [1:0] EP2 = 2'b00;
    localparam logic [1:0] EP4 = 2'b01;
    localparam logic [1:0] EP6 = 2'b10;
    localparam logic [1:0] EP8 = 2'b11;

    localparam bit DIR_OUT = 1'b0;
    localparam bit DIR_IN  = 1'b1;

    localparam int FD_W = 8;
endpackage

// File: rtl/fx2_ep_fifo_if.sv
// Endpoint bus: FPGA-side slave-FIFO pins, host-side push/pop port and status.
// master = whoever drives the endpoint (fixture/bench), slave = the endpoint model.
interface fx2_ep_fifo_if #(
    parameter int AW = 9
);
    import fx2_pkg::*;

    logic [1:0]      fifoadr;
    logic            strobe_n;
    logic [FD_W-1:0] fpga_wdata;
    logic [FD_W-1:0] fpga_rdata;
    logic            flag_n;
    logic            host_wr;
    logic [FD_W-1:0] host_wdata;
    logic            host_rd;
    logic [FD_W-1:0] host_rdata;
    logic [AW:0]     count;
    logic            err;

    modport master (
        output fifoadr, strobe_n, fpga_wdata, host_wr, host_wdata, host_rd,
        input  fpga_rdata, flag_n, host_rdata, count, err
    );

    modport slave (
        input  fifoadr, strobe_n, fpga_wdata, host_wr, host_wdata, host_rd,
        output fpga_rdata, flag_n, host_rdata, count, err
    );
endinterface

// File: rtl/fx2_fifo_core.sv
// Single-clock first-word-fall-through FIFO with guarded push/pop and an
// AW+1 bit occupancy counter so full and empty are distinguishable.
module fx2_fifo_core
    import fx2_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [FD_W-1:0] i_wdata,
    output logic [FD_W-1:0] o_rdata,
    output logic [AW:0]     o_count,
    output logic            o_push_rej,
    output logic            o_pop_rej
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    // Memory write lives in the non-reset branch so nothing is stored while reset is low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_push_rej = i_push && w_full;
    assign o_pop_rej  = i_pop && w_empty;
endmodule

// File: rtl/fx2_ep_fifo.sv
// One FX2 slave-FIFO endpoint: address decode, active-low strobe, direction
// muxing of push/pop sources, EMPTY#/FULL# flag and sticky error.
module fx2_ep_fifo
    import fx2_pkg::*;
#(
    parameter logic [1:0] FIFOADR = EP2,
    parameter bit         DIR     = DIR_OUT,
    parameter int         DEPTH   = 512,
    parameter int         AW      = 9
) (
    input  logic             ifclk,
    input  logic             reset_n,
    fx2_ep_fifo_if.slave     bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic            w_fpga_acc;
    logic            w_push;
    logic            w_pop;
    logic [FD_W-1:0] w_wdata;
    logic [FD_W-1:0] w_rdata;
    logic [AW:0]     w_count;
    logic            w_push_rej;
    logic            w_pop_rej;
    logic            r_err;

    assign w_fpga_acc = (bus.fifoadr == FIFOADR) && !bus.strobe_n;

    // OUT: host fills, FPGA drains. IN: FPGA fills, host drains.
    assign w_push  = (DIR == DIR_IN) ? w_fpga_acc     : bus.host_wr;
    assign w_pop   = (DIR == DIR_IN) ? bus.host_rd    : w_fpga_acc;
    assign w_wdata = (DIR == DIR_IN) ? bus.fpga_wdata : bus.host_wdata;

    fx2_fifo_core #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .i_clk      (ifclk),
        .i_rst_n    (reset_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_wdata    (w_wdata),
        .o_rdata    (w_rdata),
        .o_count    (w_count),
        .o_push_rej (w_push_rej),
        .o_pop_rej  (w_pop_rej)
    );

    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_push_rej || w_pop_rej) begin
            r_err <= 1'b1;
        end
    end

    assign bus.fpga_rdata = (DIR == DIR_OUT) ? w_rdata : '0;
    assign bus.host_rdata = (DIR == DIR_IN)  ? w_rdata : '0;
    assign bus.flag_n     = (DIR == DIR_IN)  ? (w_count != FULL_CNT) : (w_count != '0);
    assign bus.count      = w_count;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_fx2_ep_fifo.sv
// Bench for fx2_ep_fifo: an OUT endpoint at EP2 and an IN endpoint at EP6,
// checked against queue-based models of each endpoint.
module tb_fx2_ep_fifo;
    import fx2_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fx2_ep_fifo_if #(.AW(AW)) out_if ();
    fx2_ep_fifo_if #(.AW(AW)) in_if ();

    fx2_ep_fifo #(.FIFOADR(EP2), .DIR(DIR_OUT), .DEPTH(DEPTH), .AW(AW)) u_out (
        .ifclk   (clk),
        .reset_n (rst_n),
        .bus     (out_if.slave)
    );

    fx2_ep_fifo #(.FIFOADR(EP6), .DIR(DIR_IN), .DEPTH(DEPTH), .AW(AW)) u_in (
        .ifclk   (clk),
        .reset_n (rst_n),
        .bus     (in_if.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] q_out[$];
    logic [7:0] q_in[$];
    bit         m_err_out = 1'b0;
    bit         m_err_in  = 1'b0;

    task automatic idle();
        out_if.fifoadr = EP2; out_if.strobe_n = 1'b1; out_if.fpga_wdata = 8'h00;
        out_if.host_wr = 1'b0; out_if.host_wdata = 8'h00; out_if.host_rd = 1'b0;
        in_if.fifoadr = EP6; in_if.strobe_n = 1'b1; in_if.fpga_wdata = 8'h00;
        in_if.host_wr = 1'b0; in_if.host_wdata = 8'h00; in_if.host_rd = 1'b0;
    endtask

    // Advance one clock and apply the endpoint rules to the reference queues.
    task automatic tick();
        bit o_pop, o_push, i_push, i_pop;
        bit o_pop_ok, o_push_ok, i_push_ok, i_pop_ok;
        logic [7:0] o_d, i_d;
        o_pop  = (out_if.fifoadr == EP2) && !out_if.strobe_n;
        o_push = out_if.host_wr;
        o_d    = out_if.host_wdata;
        i_push = (in_if.fifoadr == EP6) && !in_if.strobe_n;
        i_pop  = in_if.host_rd;
        i_d    = in_if.fpga_wdata;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q_out.delete(); q_in.delete();
            m_err_out = 1'b0; m_err_in = 1'b0;
        end else begin
            o_pop_ok  = o_pop && (q_out.size() != 0);
            o_push_ok = o_push && (q_out.size() != DEPTH);
            i_pop_ok  = i_pop && (q_in.size() != 0);
            i_push_ok = i_push && (q_in.size() != DEPTH);
            if ((o_pop && !o_pop_ok) || (o_push && !o_push_ok)) m_err_out = 1'b1;
            if ((i_pop && !i_pop_ok) || (i_push && !i_push_ok)) m_err_in = 1'b1;
            if (o_pop_ok) void'(q_out.pop_front());
            if (o_push_ok) q_out.push_back(o_d);
            if (i_pop_ok) void'(q_in.pop_front());
            if (i_push_ok) q_in.push_back(i_d);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_if.count !== 10'd0) begin bad++; $display("FAIL reset_out_count got=%0d exp=0", out_if.count); end
        total++; if (out_if.flag_n !== 1'b0) begin bad++; $display("FAIL reset_out_flag got=%b exp=0", out_if.flag_n); end
        total++; if (out_if.fpga_rdata !== 8'h00) begin bad++; $display("FAIL reset_out_rdata got=%h exp=00", out_if.fpga_rdata); end
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b exp=0", out_if.err); end
        total++; if (in_if.flag_n !== 1'b1) begin bad++; $display("FAIL reset_in_flag got=%b exp=1", in_if.flag_n); end
        total++; if (in_if.count !== 10'd0) begin bad++; $display("FAIL reset_in_count got=%0d exp=0", in_if.count); end
        total++; if (in_if.host_rdata !== 8'h00) begin bad++; $display("FAIL reset_in_rdata got=%h exp=00", in_if.host_rdata); end
        total++; if (in_if.err !== 1'b0) begin bad++; $display("FAIL reset_in_err got=%b exp=0", in_if.err); end
        q_out.delete(); q_in.delete(); m_err_out = 1'b0; m_err_in = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_out_basic();
        out_if.host_wr = 1'b1;
        out_if.host_wdata = 8'hA5; tick();
        out_if.host_wdata = 8'h3C; tick();
        out_if.host_wr = 1'b0;
        total++; if (out_if.count !== 10'd2) begin bad++; $display("FAIL out_fill_count got=%0d exp=2", out_if.count); end
        total++; if (out_if.fpga_rdata !== 8'hA5) begin bad++; $display("FAIL out_fwft_head got=%h exp=a5", out_if.fpga_rdata); end
        total++; if (out_if.flag_n !== 1'b1) begin bad++; $display("FAIL out_fill_flag got=%b exp=1", out_if.flag_n); end
        out_if.fifoadr = EP2; out_if.strobe_n = 1'b0;
        tick();
        total++; if (out_if.fpga_rdata !== 8'h3C) begin bad++; $display("FAIL out_pop1_rdata got=%h exp=3c", out_if.fpga_rdata); end
        total++; if (out_if.count !== 10'd1) begin bad++; $display("FAIL out_pop1_count got=%0d exp=1", out_if.count); end
        tick();
        out_if.strobe_n = 1'b1;
        total++; if (out_if.count !== 10'd0) begin bad++; $display("FAIL out_pop2_count got=%0d exp=0", out_if.count); end
        total++; if (out_if.flag_n !== 1'b0) begin bad++; $display("FAIL out_pop2_flag got=%b exp=0", out_if.flag_n); end
        total++; if (out_if.fpga_rdata !== 8'h00) begin bad++; $display("FAIL out_pop2_rdata got=%h exp=00", out_if.fpga_rdata); end
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL out_basic_err got=%b exp=0", out_if.err); end
        $display("test_out_basic done");
    endtask

    task automatic test_wrong_addr();
        out_if.host_wr = 1'b1; out_if.host_wdata = 8'h5A; tick(); out_if.host_wr = 1'b0;
        out_if.fifoadr = EP4; out_if.strobe_n = 1'b0;
        repeat (2) tick();
        total++; if (out_if.count !== 10'd1) begin bad++; $display("FAIL wrongaddr_count got=%0d exp=1", out_if.count); end
        total++; if (out_if.fpga_rdata !== 8'h5A) begin bad++; $display("FAIL wrongaddr_rdata got=%h exp=5a", out_if.fpga_rdata); end
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL wrongaddr_err got=%b exp=0", out_if.err); end
        out_if.fifoadr = EP2; tick(); out_if.strobe_n = 1'b1;
        // Unused-port strobes on empty endpoints must not pop, push or flag an error.
        out_if.host_rd = 1'b1; in_if.host_wr = 1'b1; in_if.host_wdata = 8'hEE;
        tick();
        out_if.host_rd = 1'b0; in_if.host_wr = 1'b0;
        total++; if (out_if.count !== 10'd0) begin bad++; $display("FAIL unused_out_count got=%0d exp=0", out_if.count); end
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL unused_out_err got=%b exp=0", out_if.err); end
        total++; if (in_if.count !== 10'd0) begin bad++; $display("FAIL unused_in_count got=%0d exp=0", in_if.count); end
        total++; if (in_if.err !== 1'b0) begin bad++; $display("FAIL unused_in_err got=%b exp=0", in_if.err); end
        $display("test_wrong_addr done");
    endtask

    task automatic test_in_full();
        logic [7:0] e;
        in_if.fifoadr = EP6; in_if.strobe_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_if.fpga_wdata = 8'(i);
            tick();
            if (i == DEPTH - 2) begin
                total++; if (in_if.flag_n !== 1'b1) begin bad++; $display("FAIL in_almost_full_flag got=%b exp=1", in_if.flag_n); end
            end
        end
        total++; if (in_if.flag_n !== 1'b0) begin bad++; $display("FAIL in_full_flag got=%b exp=0", in_if.flag_n); end
        total++; if (in_if.count !== 10'(DEPTH)) begin bad++; $display("FAIL in_full_count got=%0d exp=%0d", in_if.count, DEPTH); end
        total++; if (in_if.err !== 1'b0) begin bad++; $display("FAIL in_full_err_early got=%b exp=0", in_if.err); end
        in_if.fpga_wdata = 8'hEE; tick();
        total++; if (in_if.count !== 10'(DEPTH)) begin bad++; $display("FAIL in_overflow_count got=%0d exp=%0d", in_if.count, DEPTH); end
        total++; if (in_if.err !== 1'b1) begin bad++; $display("FAIL in_overflow_err got=%b exp=1", in_if.err); end
        total++; if (in_if.host_rdata !== 8'h00) begin bad++; $display("FAIL in_head0 got=%h exp=00", in_if.host_rdata); end
        // Full plus push plus pop: push is refused, pop still happens.
        in_if.host_rd = 1'b1; in_if.fpga_wdata = 8'hDD; tick();
        in_if.strobe_n = 1'b1;
        total++; if (in_if.count !== 10'(DEPTH - 1)) begin bad++; $display("FAIL in_fullpp_count got=%0d exp=%0d", in_if.count, DEPTH - 1); end
        total++; if (in_if.flag_n !== 1'b1) begin bad++; $display("FAIL in_fullpp_flag got=%b exp=1", in_if.flag_n); end
        for (int i = 1; i < DEPTH; i++) begin
            e = 8'(i);
            total++; if (in_if.host_rdata !== e) begin bad++; $display("FAIL in_drain_data idx=%0d got=%h exp=%h", i, in_if.host_rdata, e); end
            tick();
        end
        tick();
        in_if.host_rd = 1'b0;
        total++; if (in_if.count !== 10'd0) begin bad++; $display("FAIL in_drain_count got=%0d exp=0", in_if.count); end
        total++; if (in_if.host_rdata !== 8'h00) begin bad++; $display("FAIL in_empty_rdata got=%h exp=00", in_if.host_rdata); end
        total++; if (in_if.err !== 1'b1) begin bad++; $display("FAIL in_err_sticky got=%b exp=1", in_if.err); end
        $display("test_in_full done");
    endtask

    task automatic test_simultaneous();
        logic [7:0] fill [3] = '{8'h11, 8'h22, 8'h33};
        out_if.host_wr = 1'b1;
        for (int k = 0; k < 3; k++) begin out_if.host_wdata = fill[k]; tick(); end
        out_if.fifoadr = EP2; out_if.strobe_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            out_if.host_wdata = 8'h44 + 8'(k * 8'h11);
            tick();
            total++; if (out_if.count !== 10'd3) begin bad++; $display("FAIL simul_count k=%0d got=%0d exp=3", k, out_if.count); end
        end
        total++; if (out_if.fpga_rdata !== 8'h55) begin bad++; $display("FAIL simul_order got=%h exp=55", out_if.fpga_rdata); end
        out_if.host_wr = 1'b0;
        repeat (3) tick();
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL simul_err_early got=%b exp=0", out_if.err); end
        out_if.host_wr = 1'b1; out_if.host_wdata = 8'h99; tick();
        out_if.host_wr = 1'b0; out_if.strobe_n = 1'b1;
        total++; if (out_if.count !== 10'd1) begin bad++; $display("FAIL empty_pp_count got=%0d exp=1", out_if.count); end
        total++; if (out_if.err !== 1'b1) begin bad++; $display("FAIL empty_pp_err got=%b exp=1", out_if.err); end
        total++; if (out_if.fpga_rdata !== 8'h99) begin bad++; $display("FAIL empty_pp_rdata got=%h exp=99", out_if.fpga_rdata); end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid();
        out_if.host_wr = 1'b1;
        for (int k = 0; k < 4; k++) begin out_if.host_wdata = 8'(8'hC0 + k); tick(); end
        out_if.host_wr = 1'b0;
        in_if.strobe_n = 1'b0; in_if.fpga_wdata = 8'h42; repeat (2) tick(); in_if.strobe_n = 1'b1;
        total++; if (out_if.count !== 10'd5) begin bad++; $display("FAIL midrst_pre_count got=%0d exp=5", out_if.count); end
        #2 rst_n = 1'b0;
        #1;
        q_out.delete(); q_in.delete(); m_err_out = 1'b0; m_err_in = 1'b0;
        total++; if (out_if.count !== 10'd0) begin bad++; $display("FAIL midrst_out_count got=%0d exp=0", out_if.count); end
        total++; if (out_if.flag_n !== 1'b0) begin bad++; $display("FAIL midrst_out_flag got=%b exp=0", out_if.flag_n); end
        total++; if (out_if.fpga_rdata !== 8'h00) begin bad++; $display("FAIL midrst_out_rdata got=%h exp=00", out_if.fpga_rdata); end
        total++; if (out_if.err !== 1'b0) begin bad++; $display("FAIL midrst_out_err got=%b exp=0", out_if.err); end
        total++; if (in_if.count !== 10'd0) begin bad++; $display("FAIL midrst_in_count got=%0d exp=0", in_if.count); end
        total++; if (in_if.flag_n !== 1'b1) begin bad++; $display("FAIL midrst_in_flag got=%b exp=1", in_if.flag_n); end
        out_if.host_wr = 1'b1; out_if.host_wdata = 8'h77; in_if.strobe_n = 1'b0;
        tick();
        idle();
        total++; if (out_if.count !== 10'd0) begin bad++; $display("FAIL inrst_out_count got=%0d exp=0", out_if.count); end
        total++; if (in_if.count !== 10'd0) begin bad++; $display("FAIL inrst_in_count got=%0d exp=0", in_if.count); end
        rst_n = 1'b1;
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int fill_pct, drain_pct;
        logic [7:0] e_out, e_in;
        for (int c = 0; c < 3000; c++) begin
            fill_pct  = (c < 1500) ? 80 : 25;
            drain_pct = (c < 1500) ? 30 : 80;
            out_if.host_wr    = ($urandom_range(0, 99) < fill_pct);
            out_if.host_wdata = 8'($urandom);
            out_if.fifoadr    = ($urandom_range(0, 9) == 0) ? 2'($urandom) : EP2;
            out_if.strobe_n   = !($urandom_range(0, 99) < drain_pct);
            out_if.host_rd    = ($urandom_range(0, 9) == 0);
            in_if.fifoadr     = ($urandom_range(0, 9) == 0) ? 2'($urandom) : EP6;
            in_if.strobe_n    = !($urandom_range(0, 99) < fill_pct);
            in_if.fpga_wdata  = 8'($urandom);
            in_if.host_rd     = ($urandom_range(0, 99) < drain_pct);
            in_if.host_wr     = ($urandom_range(0, 9) == 0);
            tick();
            e_out = (q_out.size() != 0) ? q_out[0] : 8'h00;
            e_in  = (q_in.size() != 0) ? q_in[0] : 8'h00;
            total++; if (out_if.count !== 10'(q_out.size())) begin bad++; $display("FAIL rnd_out_count c=%0d got=%0d exp=%0d", c, out_if.count, q_out.size()); end
            total++; if (out_if.fpga_rdata !== e_out) begin bad++; $display("FAIL rnd_out_rdata c=%0d got=%h exp=%h", c, out_if.fpga_rdata, e_out); end
            total++; if (out_if.flag_n !== (q_out.size() != 0)) begin bad++; $display("FAIL rnd_out_flag c=%0d got=%b", c, out_if.flag_n); end
            total++; if (out_if.err !== m_err_out) begin bad++; $display("FAIL rnd_out_err c=%0d got=%b exp=%b", c, out_if.err, m_err_out); end
            total++; if (in_if.count !== 10'(q_in.size())) begin bad++; $display("FAIL rnd_in_count c=%0d got=%0d exp=%0d", c, in_if.count, q_in.size()); end
            total++; if (in_if.host_rdata !== e_in) begin bad++; $display("FAIL rnd_in_rdata c=%0d got=%h exp=%h", c, in_if.host_rdata, e_in); end
            total++; if (in_if.flag_n !== (q_in.size() != DEPTH)) begin bad++; $display("FAIL rnd_in_flag c=%0d got=%b", c, in_if.flag_n); end
            total++; if (in_if.err !== m_err_in) begin bad++; $display("FAIL rnd_in_err c=%0d got=%b exp=%b", c, in_if.err, m_err_in); end
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_out_basic();
        test_wrong_addr();
        test_in_full();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
